// File: rtl/cdc_afifo_lvl.sv
// cdc_afifo_lvl: dual-clock FIFO with occupancy counts and almost-full /
// almost-empty flags in both domains. Pointers cross as Gray code through
// two-flop synchronisers; storage is an unreset register array read
// combinationally (first-word fall-through).
// Optional feature macro: CDC_AFIFO_LVL_ERR_EN enables the sticky
// overflow / underflow flags; without it both flags are constant 0.
module cdc_afifo_lvl #(
   parameter int abits      = 3,
   parameter int dbits      = 32,
   parameter int afull_lvl  = 6,
   parameter int aempty_lvl = 1
) (
   input  logic             i_nrst,
   input  logic             i_wclk,
   input  logic             i_rclk,
   input  logic             i_wr,
   input  logic [dbits-1:0] i_wdata,
   output logic             o_wfull,
   output logic             o_wafull,
   output logic [abits:0]   o_wcount,
   output logic             o_wovf,
   input  logic             i_rd,
   output logic [dbits-1:0] o_rdata,
   output logic             o_rempty,
   output logic             o_raempty,
   output logic [abits:0]   o_rcount,
   output logic             o_rudf
);

   localparam int DEPTH = 2 ** abits;

   typedef logic [abits:0] ptr_t;

   localparam ptr_t AFULL  = ptr_t'(afull_lvl);
   localparam ptr_t AEMPTY = ptr_t'(aempty_lvl);

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[abits] = g[abits];
      for (int i = abits - 1; i >= 0; i--) begin
         b[i] = b[i + 1] ^ g[i];
      end
      return b;
   endfunction

   logic [dbits-1:0] mem [DEPTH];

   // write-domain state
   ptr_t wbin, wgray, wq1_rgray, wq2_rgray;
   ptr_t wbin_nxt, wgray_nxt, rgray_as_full;
   logic wfull, w_acc;

   // read-domain state
   ptr_t rbin, rgray, rq1_wgray, rq2_wgray;
   ptr_t rbin_nxt, rgray_nxt;
   logic rempty, r_acc;

   // ---------------- write domain ----------------
   assign w_acc     = i_wr & ~wfull;
   assign wbin_nxt  = wbin + ptr_t'(w_acc);
   assign wgray_nxt = bin2gray(wbin_nxt);

   // The writer is exactly one lap ahead when the Gray pointers differ only
   // in their top two bits.
   assign rgray_as_full = {~wq2_rgray[abits:abits-1], wq2_rgray[abits-2:0]};

   // Write pointer advance and registered full flag.
   always_ff @(posedge i_wclk or negedge i_nrst) begin
      if (!i_nrst) begin
         wbin  <= '0;
         wgray <= '0;
         wfull <= 1'b0;
      end else begin
         wbin  <= wbin_nxt;
         wgray <= wgray_nxt;
         wfull <= (wgray_nxt == rgray_as_full);
      end
   end

   // Bring the read Gray pointer into the write clock domain.
   always_ff @(posedge i_wclk or negedge i_nrst) begin
      if (!i_nrst) begin
         wq1_rgray <= '0;
         wq2_rgray <= '0;
      end else begin
         wq1_rgray <= rgray;
         wq2_rgray <= wq1_rgray;
      end
   end

   // Payload storage; deliberately unreset so reset only touches pointers.
   always_ff @(posedge i_wclk) begin
      if (w_acc) begin
         mem[wbin[abits-1:0]] <= i_wdata;
      end
   end

   // The synchronised read pointer lags, so this count can only over-report.
   assign o_wcount = wbin - gray2bin(wq2_rgray);
   assign o_wafull = (o_wcount >= AFULL);
   assign o_wfull  = wfull;

   // ---------------- read domain ----------------
   assign r_acc     = i_rd & ~rempty;
   assign rbin_nxt  = rbin + ptr_t'(r_acc);
   assign rgray_nxt = bin2gray(rbin_nxt);

   // Read pointer advance and registered empty flag.
   always_ff @(posedge i_rclk or negedge i_nrst) begin
      if (!i_nrst) begin
         rbin   <= '0;
         rgray  <= '0;
         rempty <= 1'b1;
      end else begin
         rbin   <= rbin_nxt;
         rgray  <= rgray_nxt;
         rempty <= (rgray_nxt == rq2_wgray);
      end
   end

   // Bring the write Gray pointer into the read clock domain.
   always_ff @(posedge i_rclk or negedge i_nrst) begin
      if (!i_nrst) begin
         rq1_wgray <= '0;
         rq2_wgray <= '0;
      end else begin
         rq1_wgray <= wgray;
         rq2_wgray <= rq1_wgray;
      end
   end

   // The synchronised write pointer lags, so this count can only under-report.
   assign o_rcount  = gray2bin(rq2_wgray) - rbin;
   assign o_raempty = (o_rcount <= AEMPTY);
   assign o_rempty  = rempty;
   assign o_rdata   = mem[rbin[abits-1:0]];

   // ---------------- sticky error flags ----------------
`ifdef CDC_AFIFO_LVL_ERR_EN
   logic wovf, rudf;

   // Remember any write attempted while full.
   always_ff @(posedge i_wclk or negedge i_nrst) begin
      if (!i_nrst) begin
         wovf <= 1'b0;
      end else if (i_wr && wfull) begin
         wovf <= 1'b1;
      end
   end

   // Remember any read attempted while empty.
   always_ff @(posedge i_rclk or negedge i_nrst) begin
      if (!i_nrst) begin
         rudf <= 1'b0;
      end else if (i_rd && rempty) begin
         rudf <= 1'b1;
      end
   end

   assign o_wovf = wovf;
   assign o_rudf = rudf;
`else
   assign o_wovf = 1'b0;
   assign o_rudf = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_afifo_lvl.sv
// Self-checking bench for cdc_afifo_lvl: directed checks of reset, fill,
// latency, error flags and mid-traffic reset, plus randomized streaming in
// both clock ratios against a queue-based reference model.
`timescale 1ns/1ps
module tb_cdc_afifo_lvl;

   localparam int ABITS  = 3;
   localparam int DBITS  = 32;
   localparam int DEPTH  = 8;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 1;
`ifdef CDC_AFIFO_LVL_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic             nrst = 1'b0;
   logic             wclk, rclk;
   logic             wr = 1'b0;
   logic [DBITS-1:0] wdata = '0;
   logic             rd = 1'b0;
   logic             wfull, wafull, wovf, rempty, raempty, rudf;
   logic [ABITS:0]   wcount, rcount;
   logic [DBITS-1:0] rdata;

   realtime whalf = 5.0;
   realtime rhalf = 13.5;

   int n_chk = 0;
   int n_bad = 0;

   // reference model: queue of accepted words and access counts
   logic [DBITS-1:0] q[$];
   int nwr = 0;
   int nrd = 0;
   int n_rx = 0;

   cdc_afifo_lvl #(
      .abits(ABITS), .dbits(DBITS), .afull_lvl(AFULL), .aempty_lvl(AEMPTY)
   ) dut (
      .i_nrst(nrst), .i_wclk(wclk), .i_rclk(rclk),
      .i_wr(wr), .i_wdata(wdata), .o_wfull(wfull), .o_wafull(wafull),
      .o_wcount(wcount), .o_wovf(wovf),
      .i_rd(rd), .o_rdata(rdata), .o_rempty(rempty), .o_raempty(raempty),
      .o_rcount(rcount), .o_rudf(rudf)
   );

   initial begin
      wclk = 1'b0;
      forever #(whalf) wclk = ~wclk;
   end

   initial begin
      rclk = 1'b0;
      forever #(rhalf) rclk = ~rclk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: accepted writes
   always @(posedge wclk) begin
      if (nrst && wr && !wfull) begin
         q.push_back(wdata);
         nwr++;
      end
   end

   // model: accepted reads, data must come out in write order
   always @(posedge rclk) begin
      if (nrst && rd && !rempty) begin
         if (q.size() == 0) begin
            check("rd_beyond_written", 64'(q.size()), 64'd1);
         end else begin
            check("rdata_order", rdata, q.pop_front());
         end
         nrd++;
         n_rx++;
      end
   end

   // model: reset empties the model
   always @(negedge nrst) begin
      q.delete();
      nwr = 0;
      nrd = 0;
   end

   // writer-side invariants
   always @(negedge wclk) begin
      if (nrst) begin
         check("wcount_ge_occ", 64'(int'(wcount) >= (nwr - nrd)), 64'd1);
         check("wcount_le_depth", 64'(int'(wcount) <= DEPTH), 64'd1);
         check("wafull_rule", 64'(wafull), 64'(int'(wcount) >= AFULL));
         check("notfull_room", 64'(wfull || (int'(wcount) < DEPTH)), 64'd1);
      end
   end

   // reader-side invariants
   always @(negedge rclk) begin
      if (nrst) begin
         check("rcount_le_occ", 64'(int'(rcount) <= (nwr - nrd)), 64'd1);
         check("raempty_rule", 64'(raempty), 64'(int'(rcount) <= AEMPTY));
         check("notempty_data", 64'(rempty || (rcount != 0)), 64'd1);
      end
   end

   task automatic wr_one(input logic [DBITS-1:0] d);
      @(negedge wclk);
      wr = 1'b1;
      wdata = d;
      @(negedge wclk);
      wr = 1'b0;
   endtask

   task automatic rd_one();
      @(negedge rclk);
      rd = 1'b1;
      @(negedge rclk);
      rd = 1'b0;
   endtask

   task automatic wait_rne(input string tag);
      int n = 0;
      while (rempty && n < 50) begin
         @(negedge rclk);
         n++;
      end
      check(tag, 64'(rempty), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_wfull"},   64'(wfull),   64'd0);
      check({tag, "_wafull"},  64'(wafull),  64'd0);
      check({tag, "_wcount"},  64'(wcount),  64'd0);
      check({tag, "_wovf"},    64'(wovf),    64'd0);
      check({tag, "_rempty"},  64'(rempty),  64'd1);
      check({tag, "_raempty"}, 64'(raempty), 64'd1);
      check({tag, "_rcount"},  64'(rcount),  64'd0);
      check({tag, "_rudf"},    64'(rudf),    64'd0);
   endtask

   task automatic stream_wr();
      int idx = 0;
      int cyc = 0;
      logic acc = 1'b0;
      while (idx < 100 && cyc < 20000) begin
         @(negedge wclk);
         cyc++;
         if (acc) idx++;
         acc = 1'b0;
         if (idx < 100) begin
            wr = ($urandom_range(0, 3) != 0) && !wfull;
            wdata = DBITS'(idx);
            acc = wr;
         end else begin
            wr = 1'b0;
         end
      end
      wr = 1'b0;
      check("stream_wr_count", 64'(idx), 64'd100);
   endtask

   task automatic stream_rd();
      int cyc = 0;
      while (n_rx < 100 && cyc < 20000) begin
         @(negedge rclk);
         cyc++;
         rd = ($urandom_range(0, 2) != 0) && !rempty;
      end
      rd = 1'b0;
   endtask

   task automatic stream_pass(input string tag);
      n_rx = 0;
      fork
         stream_wr();
         stream_rd();
      join
      check({tag, "_rx_count"}, 64'(n_rx), 64'd100);
      check({tag, "_wraps_gt10"}, 64'((n_rx / DEPTH) > 10), 64'd1);
      check({tag, "_model_empty"}, 64'(q.size()), 64'd0);
   endtask

   // global watchdog so the run always ends
   initial begin
      #1ms;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;

      // reset and idle
      #30.3;
      check_reset_vals("in_reset");
      nrst = 1'b1;
      repeat (10) @(negedge wclk);
      check_reset_vals("idle");

      // fill 0..7 with no reads
      for (int i = 0; i < DEPTH; i++) begin
         wr_one(DBITS'(i));
         check("fill_wcount", 64'(wcount), 64'(i + 1));
         check("fill_wafull", 64'(wafull), 64'((i + 1) >= AFULL));
         check("fill_wfull", 64'(wfull), 64'(i == DEPTH - 1));
      end
      wr_one(32'hFF);
      check("drop_wfull", 64'(wfull), 64'd1);
      check("drop_wcount", 64'(wcount), 64'(DEPTH));
      check("ovf_set", 64'(wovf), 64'(ERR));

      // drain and confirm order
      wait_rne("fill_rne_timeout");
      repeat (4) @(negedge rclk);
      check("drain_rcount_full", 64'(rcount), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_rdata", rdata, DBITS'(i));
         check("drain_rcount", 64'(rcount), 64'(DEPTH - i));
         rd_one();
      end
      check("drain_empty", 64'(rempty), 64'd1);
      check("drain_rcount0", 64'(rcount), 64'd0);
      rd_one();
      check("udf_set", 64'(rudf), 64'(ERR));
      repeat (4) @(negedge wclk);
      check("release_wfull", 64'(wfull), 64'd0);
      check("release_wcount", 64'(wcount), 64'd0);

      // write-to-read latency of a single word
      @(negedge wclk);
      wr = 1'b1;
      wdata = 32'hA5;
      @(posedge wclk);
      fork
         begin
            #1 wr = 1'b0;
         end
      join_none
      k = 0;
      while (rempty && k < 10) begin
         @(posedge rclk);
         #1;
         k++;
      end
      check("lat_edges", 64'(k), 64'd3);
      check("lat_rdata", rdata, 32'hA5);
      rd_one();
      check("lat_empty_after", 64'(rempty), 64'd1);

      // randomized streams in both clock ratios
      whalf = 10.0;
      rhalf = 3.7037;
      stream_pass("fast_rd");
      whalf = 3.7037;
      rhalf = 10.0;
      stream_pass("fast_wr");

      // sticky flags survive traffic
      check("ovf_persist", 64'(wovf), 64'(ERR));
      check("udf_persist", 64'(rudf), 64'(ERR));

      // reset mid-burst with 5 words queued
      whalf = 5.0;
      rhalf = 13.5;
      for (int i = 0; i < 5; i++) wr_one(32'h100 + DBITS'(i));
      repeat (6) @(negedge rclk);
      check("burst_rcount", 64'(rcount), 64'd5);
      #2.3;
      nrst = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      #20.3;
      nrst = 1'b1;
      wr_one(32'h5A);
      wait_rne("post_rst_rne_timeout");
      check("post_rst_rdata", rdata, 32'h5A);
      check("post_rst_rcount", 64'(rcount), 64'd1);
      rd_one();
      check("post_rst_empty", 64'(rempty), 64'd1);
      check("post_rst_flags", 64'({wovf, rudf}), 64'd0);
      repeat (4) @(negedge wclk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
